// File: rtl/seg_mux_scheduler_if.sv
// Shared display bus between the value producer and seg_mux_scheduler:
// load strobe/value in, commit acknowledge and multiplexed segment drive out.
interface seg_mux_scheduler_if;
    logic       ld;
    logic [7:0] din;
    logic       ack;
    logic [6:0] seg;
    logic       sel;

    modport master (output ld, output din, input ack, input seg, input sel);
    modport slave  (input ld, input din, output ack, output seg, output sel);
endinterface

// File: rtl/seg_mux_scheduler.sv
// Two-digit hex 7-segment time-multiplexer with dead-time blanking and frame-aligned value commit.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (blanks digit 1 when it is zero).
module seg_mux_scheduler #(
    parameter int unsigned DIV_W = 10,
    parameter int unsigned DEAD  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    seg_mux_scheduler_if.slave   bus
);

    localparam int unsigned SHOW_LEN = 1 << DIV_W;
    localparam int unsigned CNT_W    = (DIV_W > 8) ? DIV_W : 8;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } phase_e;

    phase_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_c;
    logic               commit_c;

    logic [7:0]         disp_q, disp_d;
    logic [7:0]         pend_q, pend_d;
    logic               pv_q, pv_d;

    logic [6:0]         seg_q, seg_d;
    logic               sel_q, sel_d;
    logic               ack_q, ack_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // State register, phase counter and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BLANK0;
            cnt_q   <= '0;
            disp_q  <= 8'h00;
            pend_q  <= 8'h00;
            pv_q    <= 1'b0;
            seg_q   <= 7'h00;
            sel_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end

    // Next phase: counter clears on every phase transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        last_c  = 1'b0;
        if (state_q == BLANK0 || state_q == BLANK1) begin
            last_c = (cnt_q == CNT_W'(DEAD - 1));
        end else begin
            last_c = (cnt_q == CNT_W'(SHOW_LEN - 1));
        end
        if (last_c) begin
            cnt_d = '0;
            case (state_q)
                BLANK0: state_d = SHOW0;
                SHOW0:  state_d = BLANK1;
                BLANK1: state_d = SHOW1;
                SHOW1:  state_d = BLANK0;
            endcase
        end
        commit_c = last_c && (state_q == SHOW1);
    end

    // Pending/display registers; a load on the commit edge bypasses PEND
    always_comb begin
        disp_d = disp_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        ack_d  = 1'b0;
        if (commit_c) begin
            if (bus.ld) begin
                disp_d = bus.din;
                ack_d  = 1'b1;
            end else if (pv_q) begin
                disp_d = pend_q;
                ack_d  = 1'b1;
            end
            pv_d = 1'b0;
        end else if (bus.ld) begin
            pend_d = bus.din;
            pv_d   = 1'b1;
        end
    end

    // Outputs follow the phase being entered so they line up with the state register
    always_comb begin
        seg_d = 7'h00;
        sel_d = 1'b0;
        case (state_d)
            BLANK0: sel_d = 1'b0;
            SHOW0:  seg_d = decode(disp_d[3:0]);
            BLANK1: sel_d = 1'b1;
            SHOW1: begin
                sel_d = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                seg_d = (disp_d[7:4] == 4'h0) ? 7'h00 : decode(disp_d[7:4]);
`else
                seg_d = decode(disp_d[7:4]);
`endif
            end
        endcase
    end

    assign bus.seg = seg_q;
    assign bus.sel = sel_q;
    assign bus.ack = ack_q;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Scoreboard bench for seg_mux_scheduler: a frame-position reference model predicts SEG/SEL/ACK each cycle.
module tb_seg_mux_scheduler;

    localparam int unsigned DIV_W    = 2;
    localparam int unsigned DEAD     = 1;
    localparam int unsigned SHOW_LEN = 1 << DIV_W;
    localparam int unsigned FRAME    = 2 * (DEAD + SHOW_LEN);

    typedef struct packed {
        logic       ack;
        logic       sel;
        logic [6:0] seg;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_mux_scheduler_if bus();

    seg_mux_scheduler #(.DIV_W(DIV_W), .DEAD(DEAD)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    out_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_acks  = 0;
    int   obs_acks  = 0;
    int   cyc       = 0;

    // Reference model: cycle index within the run since the last reset edge
    int         k = 1;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_pv   = 1'b0;
    bit         m_ack  = 1'b0;

    function automatic int pos_of(input int kk);
        return (kk - 1) % FRAME;
    endfunction

    function automatic out_t predict(input int kk, input logic [7:0] disp, input bit ack);
        out_t       e;
        int         p;
        bit         show;
        logic [3:0] dig;
        p     = pos_of(kk);
        e.sel = (p >= int'(DEAD + SHOW_LEN));
        show  = e.sel ? (p >= int'(2 * DEAD + SHOW_LEN)) : (p >= int'(DEAD));
        dig   = e.sel ? disp[7:4] : disp[3:0];
        e.seg = show ? seg_tab[dig] : 7'h00;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (e.sel && dig == 4'h0) e.seg = 7'h00;
`endif
        e.ack = ack;
        return e;
    endfunction

    // Drive one edge's inputs, advance the model over that edge, queue the expected outputs
    task automatic step(input bit r, input bit l, input logic [7:0] d);
        rst     = r;
        bus.ld  = l;
        bus.din = d;
        if (r) begin
            k = 1; m_disp = 8'h00; m_pend = 8'h00; m_pv = 1'b0; m_ack = 1'b0;
        end else begin
            k++;
            m_ack = 1'b0;
            if (pos_of(k) == 0) begin
                if (l) begin
                    m_disp = d; m_ack = 1'b1;
                end else if (m_pv) begin
                    m_disp = m_pend; m_ack = 1'b1;
                end
                m_pv = 1'b0;
            end else if (l) begin
                m_pend = d; m_pv = 1'b1;
            end
        end
        if (m_ack) exp_acks++;
        exp_q.push_back(predict(k, m_disp, m_ack));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_until(input int p);
        for (int n = 0; n < int'(FRAME) && pos_of(k + 1) != p; n++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: one expected entry per clock, compared just after the active edge
    initial begin
        out_t got;
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            checks++;
            got = {bus.ack, bus.sel, bus.seg};
            if (got.ack === 1'b1) obs_acks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty cycle=%0d got ack=%b sel=%b seg=%h", cyc, got.ack, got.sel, got.seg);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL out cycle=%0d got ack=%b sel=%b seg=%h expected ack=%b sel=%b seg=%h",
                             cyc, got.ack, got.sel, got.seg, e.ack, e.sel, e.seg);
                end
            end
        end
    end

    initial begin
        bus.ld  = 1'b0;
        bus.din = 8'h00;
        rst     = 1'b1;

        // Reset and plain sequencing
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(12);

        // Load during SHOW0, commit at frame end
        idle_until(2);
        step(1'b0, 1'b1, 8'h4A);
        idle(2 * FRAME);

        // Overwrite within one frame: only the last value is committed
        idle_until(1);
        step(1'b0, 1'b1, 8'h12);
        idle(2);
        step(1'b0, 1'b1, 8'h34);
        idle(2 * FRAME);

        // Load on the commit edge while another value is pending
        idle_until(3);
        step(1'b0, 1'b1, 8'h78);
        idle_until(0);
        step(1'b0, 1'b1, 8'h56);
        idle(2 * FRAME);

        // Reset while a value is pending
        idle_until(2);
        step(1'b0, 1'b1, 8'h99);
        idle_until(int'(DEAD + SHOW_LEN));
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * FRAME);

        // Leading-zero digit 1
        idle_until(4);
        step(1'b0, 1'b1, 8'h07);
        idle(2 * FRAME);

        // Randomized loads with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        idle(FRAME);

        checks++;
        if (obs_acks != exp_acks) begin
            failures++;
            $display("FAIL ack_count got=%0d expected=%0d", obs_acks, exp_acks);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
